fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Directly upstream of decode.
- Holds the PC and fetches from instruction memory over a req/ready handshake with one request in flight.
- Registers the instruction and PC+4 into the IF/ID outputs. Inserts NOP bubbles while memory stalls.
- Applies branch/jump redirects from decode and squashes the sequentially fetched instruction (no delay slot).

Parameters:
- RESET_PC, 32'h0000_0000, PC after reset.
- EXC_VECTOR, 32'h0000_0080, redirect target on misaligned target (optional feature only).
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll r0,r0,0).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_if_selpcsource  in  1  1 = redirect this cycle.
- id_if_selpctype  in  2  target select: 00 branch, 01 jump index, 10 register, 11 reserved.
- id_if_pcimd2ext  in  32  branch target.
- id_if_pcindex  in  32  jump target.
- id_if_rega  in  32  register target (jr/jalr).
- if_mem_req  out  1  fetch request.
- if_mem_addr  out  32  fetch address, word aligned.
- mem_if_ready  in  1  request accepted; data valid this cycle.
- mem_if_data  in  32  instruction word.
- if_id_instruc  out  32  instruction to decode.
- if_id_nextpc  out  32  fetched PC + 4.

Behaviour:
- Reset (async, active-low) values:
  - pc = RESET_PC, state = IDLE, tgt_q = 0.
  - if_id_instruc = NOP_INSTR, if_id_nextpc = RESET_PC.
  - if_mem_req = 0.
- Target mux (combinational): selpctype 00 → pcimd2ext, 01 → pcindex, 10 → rega, 11 → pcimd2ext. A redirect is taken when id_if_selpcsource = 1.
- if_mem_addr = pc in IDLE/FETCH and the held address in KILL. It must stay stable while if_mem_req = 1 and mem_if_ready = 0.
- States:
  - IDLE:
    - First cycle after reset release.
    - if_mem_req = 0, IF/ID = NOP.
    - Next state: FETCH.
  - FETCH: if_mem_req = 1.
    - ready & no redirect: if_id_instruc ← mem_if_data, if_id_nextpc ← pc+4, pc ← pc+4.
    - ready & redirect: data discarded, IF/ID ← NOP, pc ← target, stay FETCH.
    - no ready & no redirect: IF/ID ← NOP, pc held.
    - no ready & redirect: tgt_q ← target, IF/ID ← NOP, next state KILL. The address is not changed mid-handshake.
  - KILL: if_mem_req = 1 on the old address, IF/ID ← NOP.
    - On ready: data discarded, pc ← tgt_q, next state FETCH.
    - A redirect while in KILL overwrites tgt_q (last one wins).
- Latency: zero-wait memory gives one instruction per cycle, with if_id_instruc registered one cycle after the request.
- Redirect penalty: one bubble (zero-wait memory).
- If_id_nextpc on bubbles holds its previous value. Decode ignores it for NOP.
- Arithmetic: pc+4 is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is silent.
- Reset asserted mid-handshake: everything returns to reset values immediately. Any memory response arriving after reset release while in IDLE is ignored (req = 0).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect whose target[1:0] ≠ 0 is replaced by EXC_VECTOR, and output if_exc_misalign (1 bit, reset 0) pulses high for one cycle, registered with the redirect.
- Undefined: port absent. Target bits [1:0] are forced to 00 before loading pc.

Decomposition:
- Package fetch_pkg holds:
  - state enum IDLE/FETCH/KILL (2 bits);
  - selpctype encodings PCT_BRANCH/PCT_JUMP/PCT_REG/PCT_RSVD;
  - NOP_INSTR constant.
- One sub-module, fetch_target_mux: combinational selpctype decode plus alignment handling.

Test Plan:
- Reset and sequencing: assert reset low mid-run → all outputs at reset values immediately. Release → cycle 1 req = 0, cycle 2 req = 1, addr = 0.
- Zero-wait stream: ready tied 1, memory returns addr>>2 → if_id_instruc = 0,1,2,3 on consecutive cycles; if_id_nextpc = 4,8,12,16.
- Wait states: ready low 3 cycles at addr 0x8 → addr stable at 0x8, three NOP outputs, then instruc = 2, nextpc = 0xC.
- Branch with zero-wait: redirect with selpctype 00 and pcimd2ext = 0x40 while fetching 0x10 → word at 0x10 squashed (NOP), next addr = 0x40.
- Redirect during wait: redirect (selpctype 10, rega = 0x200) while addr 0x20 is unacknowledged → addr holds 0x20 until ready, data discarded as NOP, next addr = 0x200.
- FETCH_MISALIGN_TRAP_EN: redirect with selpctype 01 and pcindex = 0x102 → if_exc_misalign pulse, next addr = 0x80. Macro undefined: next addr = 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS IF stage: FSM states, target-select
// encodings and the bubble instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCT_BRANCH = 2'b00,
    PCT_JUMP   = 2'b01,
    PCT_REG    = 2'b10,
    PCT_RSVD   = 2'b11
  } pctype_e;

  // sll r0,r0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_mux.sv
// Redirect target select and alignment handling for the IF stage.
// FETCH_MISALIGN_TRAP_EN: misaligned targets go to EXC_VECTOR and raise misalign.
module fetch_target_mux
  import fetch_pkg::*;
`ifdef FETCH_MISALIGN_TRAP_EN
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
)
`endif
(
  input  logic [1:0]  selpctype,
  input  logic [31:0] pcimd2ext,
  input  logic [31:0] pcindex,
  input  logic [31:0] rega,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] target
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = pcimd2ext;
    case (pctype_e'(selpctype))
      PCT_BRANCH: raw_target = pcimd2ext;
      PCT_JUMP:   raw_target = pcindex;
      PCT_REG:    raw_target = rega;
      PCT_RSVD:   raw_target = pcimd2ext;
      default:    raw_target = pcimd2ext;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_comb begin
    misalign = |raw_target[1:0];
    target   = misalign ? EXC_VECTOR : raw_target;
  end
`else
  assign target = raw_target & ~32'h0000_0003;
`endif

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding instruction fetch, IF/ID register, redirects.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misaligned-target trap.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         id_if_selpcsource,
  input  logic [1:0]   id_if_selpctype,
  input  logic [31:0]  id_if_pcimd2ext,
  input  logic [31:0]  id_if_pcindex,
  input  logic [31:0]  id_if_rega,
  output logic         if_mem_req,
  output logic [31:0]  if_mem_addr,
  input  logic         mem_if_ready,
  input  logic [31:0]  mem_if_data,
  output logic [31:0]  if_id_instruc,
  output logic [31:0]  if_id_nextpc,
  output fetch_state_e dbg_state
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         if_exc_misalign
`endif
);

  // Handshake: a fetch is accepted on a cycle where if_mem_req and
  // mem_if_ready are both high; mem_if_data is valid in that same cycle and
  // if_mem_addr never changes while a request is waiting for ready.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instruc_q, instruc_d;
  logic [31:0]  nextpc_q, nextpc_d;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic exc_q, exc_d;

  fetch_target_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_mux (
    .selpctype (id_if_selpctype),
    .pcimd2ext (id_if_pcimd2ext),
    .pcindex   (id_if_pcindex),
    .rega      (id_if_rega),
    .misalign  (misalign),
    .target    (target)
  );
`else
  fetch_target_mux u_target_mux (
    .selpctype (id_if_selpctype),
    .pcimd2ext (id_if_pcimd2ext),
    .pcindex   (id_if_pcindex),
    .rega      (id_if_rega),
    .target    (target)
  );
  assign misalign = 1'b0;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instruc_d = NOP_INSTR;
    nextpc_d  = nextpc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    exc_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (id_if_selpcsource) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          exc_d = misalign;
`endif
          if (mem_if_ready) begin
            pc_d = target;
          end else begin
            // The in-flight request must complete on its old address first.
            tgt_d   = target;
            state_d = KILL;
          end
        end else if (mem_if_ready) begin
          instruc_d = mem_if_data;
          nextpc_d  = pc_plus4;
          pc_d      = pc_plus4;
        end
      end
      KILL: begin
        if (id_if_selpcsource) begin
          tgt_d = target;
`ifdef FETCH_MISALIGN_TRAP_EN
          exc_d = misalign;
`endif
        end
        if (mem_if_ready) begin
          pc_d    = id_if_selpcsource ? target : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      tgt_q     <= 32'h0000_0000;
      instruc_q <= NOP_INSTR;
      nextpc_q  <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      instruc_q <= instruc_d;
      nextpc_q  <= nextpc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      exc_q     <= exc_d;
`endif
    end
  end

  // pc is frozen during KILL, so it is also the held address of the old request.
  assign if_mem_req    = (state_q != IDLE);
  assign if_mem_addr   = pc_q;
  assign if_id_instruc = instruc_q;
  assign if_id_nextpc  = nextpc_q;
  assign dbg_state     = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_exc_misalign = exc_q;
`endif

  logic unused_misalign;
  assign unused_misalign = misalign;

endmodule
